store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the execute/memory pipeline stage and the data memory write port. The pipeline posts 64-bit stores into a small in-order FIFO and does not wait for memory. The buffer then drains one entry per cycle into data memory whenever the memory port is not taken by a load. Loads check the buffer in the same cycle and are forwarded the youngest matching pending store, so software never observes a stale memory value.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2
- AW, 64: address width
- DW, 64: data width
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ST_VALID  in  1  pipeline presents a store this cycle
- ST_ADDR  in  AW  store address
- ST_DATA  in  DW  store data
- ST_READY  out  1  buffer can accept a store (= not full)
- LD_ADDR  in  AW  address of the load in the memory stage (lookup is always active)
- LD_HIT  out  1  a pending store matches LD_ADDR
- LD_DATA  out  DW  data of the youngest matching entry; 0 when LD_HIT=0
- MEM_BUSY  in  1  data memory port is used by a load this cycle; suppresses drain
- MEM_WRITE  out  1  write enable to data memory
- MEM_ADDR_OUT  out  AW  write address (head entry)
- WRITE_DATA  out  DW  write data (head entry)
- EMPTY  out  1  no pending entries (used by fence/halt logic)
- COUNT  out  $clog2(DEPTH)+1  number of pending entries

## Operation
- Storage: circular array of DEPTH {addr, data, valid} entries, with head pointer (oldest), tail pointer and COUNT register. Pointers wrap modulo DEPTH.
- Push: ST_VALID & ST_READY at a rising edge writes {ST_ADDR, ST_DATA} at tail, sets valid, and advances tail.
- ST_VALID while full: the store is not accepted. The pipeline must hold ST_VALID/ST_ADDR/ST_DATA until ST_READY=1.
- Pop: MEM_WRITE = !EMPTY & !MEM_BUSY, combinational. At an edge with MEM_WRITE=1, data memory captures the head entry and the buffer clears head valid and advances head.
- MEM_ADDR_OUT/WRITE_DATA always show the head entry when !EMPTY, and 0 when EMPTY.
- Push and pop at the same edge: COUNT is unchanged and both pointers advance.
- ST_READY = (COUNT != DEPTH) and depends only on registered state. When full, a push is refused even if a pop happens at the same edge.
- Forwarding:
  - All valid entries are compared against LD_ADDR on the full AW bits.
  - LD_HIT=1 if any entry matches.
  - LD_DATA comes from the match closest to tail (youngest).
  - The head entry being drained this cycle still forwards.
  - A store being pushed this cycle is not forwarded; it becomes visible the next cycle.
- Duplicate addresses are kept as separate entries and drain in order. There is no coalescing.
- Control states are implied by COUNT:
  - EMPTY (COUNT=0)
  - PARTIAL (0<COUNT<DEPTH)
  - FULL (COUNT=DEPTH)
- State transitions are determined only by push/pop at each edge.
- Reset (RESET_N low, any time, asynchronous):
  - head=tail=COUNT=0 and all valid cleared.
  - Outputs immediately become: ST_READY=1, EMPTY=1, COUNT=0, MEM_WRITE=0, MEM_ADDR_OUT=0, WRITE_DATA=0, LD_HIT=0, LD_DATA=0.
  - Pending stores are discarded.
  - The buffer leaves reset at the first rising edge after RESET_N goes high.

## Timing
- The store becomes visible to forwarding 1 cycle after the accepting edge.
- Earliest memory write is at the edge after the push (1-cycle latency) when MEM_BUSY=0.
- Drain throughput is 1 entry/cycle. Each cycle with MEM_BUSY=1 adds one cycle per pending entry.
- LD_HIT/LD_DATA/MEM_WRITE/MEM_ADDR_OUT/WRITE_DATA are combinational from registered state and inputs in the same cycle.
- There is no path from ST_VALID to ST_READY.
- EMPTY=1 with no push pending guarantees all prior stores are in memory.

## Test plan
- Reset mid-operation: push 3 stores, assert RESET_N low between edges → all outputs immediately at reset values and COUNT=0. After release, no MEM_WRITE occurs.
- Single store: push addr 0x2, data 0x7 with MEM_BUSY=0 → MEM_WRITE=1, MEM_ADDR_OUT=0x2, WRITE_DATA=0x7 in the next cycle; EMPTY=1 after that edge.
- Fill and backpressure:
  - Hold MEM_BUSY=1 and push 0x10..0x13 (data 0xA0..0xA3) → COUNT=4, ST_READY=0.
  - A 5th ST_VALID is not accepted.
  - Release MEM_BUSY → writes occur in order 0x10..0x13, one per cycle. ST_READY=1 after the first pop.
- Forwarding youngest:
  - Push addr 0x5/data 0x1, then addr 0x5/data 0x2, with MEM_BUSY=1 → LD_ADDR=0x5 gives LD_HIT=1, LD_DATA=0x2.
  - LD_ADDR=0x6 gives LD_HIT=0, LD_DATA=0.
  - After both drain, LD_HIT=0.
- Simultaneous push/pop at COUNT=2 → COUNT stays 2 and order is preserved across pointer wrap (run 10 stores through DEPTH=4).
- Same-cycle push not forwarded: push addr 0x8 while LD_ADDR=0x8 and buffer empty → LD_HIT=0 in that cycle and LD_HIT=1 in the next (MEM_BUSY=1).

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order posted-write FIFO between the memory pipeline stage
// and the data memory write port, with youngest-match load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     st_valid_i,
  input  logic [AW-1:0]            st_addr_i,
  input  logic [DW-1:0]            st_data_i,
  output logic                     st_ready_o,
  input  logic [AW-1:0]            ld_addr_i,
  output logic                     ld_hit_o,
  output logic [DW-1:0]            ld_data_o,
  input  logic                     mem_busy_i,
  output logic                     mem_write_o,
  output logic [AW-1:0]            mem_addr_out_o,
  output logic [DW-1:0]            write_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic [PW-1:0]    idx;

  // Status and handshake outputs depend only on registered state, so a
  // store request can never combinationally affect its own ready.
  always_comb begin
    empty_o        = (count_q == '0);
    st_ready_o     = (count_q != CW'(DEPTH));
    count_o        = count_q;
    mem_write_o    = !empty_o && !mem_busy_i;
    mem_addr_out_o = empty_o ? '0 : addr_q[head_q];
    write_data_o   = empty_o ? '0 : data_q[head_q];
    push           = st_valid_i && st_ready_o;
    pop            = mem_write_o;
  end

  // Next-state pointers and occupancy; a simultaneous push and pop keeps
  // the count while both pointers advance.
  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry storage and pointer registers; reset discards all pending stores.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q]  <= st_addr_i;
        data_q[tail_q]  <= st_data_i;
        valid_q[tail_q] <= 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Forwarding walks entries from oldest to youngest so the last match
  // seen, the one closest to tail, supplies the load data.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + k[PW-1:0];
      if (valid_q[idx] && (addr_q[idx] == ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a per-cycle vector table plus
// hand-written reset and pointer-wrap sequences, with a scoreboard queue
// holding the expected memory write order.
module tb_store_buffer;

  logic        clk_i;
  logic        rst_ni;
  logic        st_valid_i;
  logic [63:0] st_addr_i;
  logic [63:0] st_data_i;
  logic        st_ready_o;
  logic [63:0] ld_addr_i;
  logic        ld_hit_o;
  logic [63:0] ld_data_o;
  logic        mem_busy_i;
  logic        mem_write_o;
  logic [63:0] mem_addr_out_o;
  logic [63:0] write_data_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        stValid;
    logic [63:0] stAddr;
    logic [63:0] stData;
    logic [63:0] ldAddr;
    logic        memBusy;
    logic        expReady;
    logic        expHit;
    logic [63:0] expLdData;
    logic        expWrite;
    logic [2:0]  expCount;
    logic        expEmpty;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sbQ[$];

  store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .st_valid_i     (st_valid_i),
    .st_addr_i      (st_addr_i),
    .st_data_i      (st_data_i),
    .st_ready_o     (st_ready_o),
    .ld_addr_i      (ld_addr_i),
    .ld_hit_o       (ld_hit_o),
    .ld_data_o      (ld_data_o),
    .mem_busy_i     (mem_busy_i),
    .mem_write_o    (mem_write_o),
    .mem_addr_out_o (mem_addr_out_o),
    .write_data_o   (write_data_o),
    .empty_o        (empty_o),
    .count_o        (count_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, let them settle,
  // then record accepted stores and check any memory write against the
  // scoreboard before the next rising edge.
  task automatic applyStimulus(input logic v, input logic [63:0] a,
                               input logic [63:0] d, input logic [63:0] ld,
                               input logic busy);
    wr_t e;
    st_valid_i = v;
    st_addr_i  = a;
    st_data_i  = d;
    ld_addr_i  = ld;
    mem_busy_i = busy;
    #2;
    if (st_valid_i && st_ready_o) sbQ.push_back('{addr: a, data: d});
    if (mem_write_o) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_write: got write to 0x%0h, required none",
                 mem_addr_out_o);
      end else begin
        e = sbQ.pop_front();
        checkOutput("drain_addr", mem_addr_out_o, e.addr);
        checkOutput("drain_data", write_data_o, e.data);
      end
    end
  endtask

  task automatic addVec(input logic v, input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] ld, input logic busy, input logic rdy,
                        input logic hit, input logic [63:0] ldd, input logic wr,
                        input logic [2:0] cnt, input logic emp);
    vecs.push_back('{stValid: v, stAddr: a, stData: d, ldAddr: ld, memBusy: busy,
                     expReady: rdy, expHit: hit, expLdData: ldd, expWrite: wr,
                     expCount: cnt, expEmpty: emp});
  endtask

  initial begin
    rst_ni     = 1'b0;
    st_valid_i = 1'b0;
    st_addr_i  = '0;
    st_data_i  = '0;
    ld_addr_i  = '0;
    mem_busy_i = 1'b0;

    //      v  addr   data   ld     busy rdy hit ldData wr cnt emp
    addVec(0, 0,     0,     0,     0,   1,  0,  0,     0, 0,  1);
    // single store, not forwarded in its own cycle, written next cycle
    addVec(1, 'h2,   'h7,   'h2,   0,   1,  0,  0,     0, 0,  1);
    addVec(0, 0,     0,     'h2,   0,   1,  1,  'h7,   1, 1,  0);
    addVec(0, 0,     0,     'h2,   0,   1,  0,  0,     0, 0,  1);
    // fill with memory busy
    addVec(1, 'h10,  'hA0,  'h99,  1,   1,  0,  0,     0, 0,  1);
    addVec(1, 'h11,  'hA1,  'h99,  1,   1,  0,  0,     0, 1,  0);
    addVec(1, 'h12,  'hA2,  'h99,  1,   1,  0,  0,     0, 2,  0);
    addVec(1, 'h13,  'hA3,  'h99,  1,   1,  0,  0,     0, 3,  0);
    // full: fifth store refused, also at the first popping edge
    addVec(1, 'h14,  'hA4,  'h12,  1,   0,  1,  'hA2,  0, 4,  0);
    addVec(1, 'h14,  'hA4,  'h10,  0,   0,  1,  'hA0,  1, 4,  0);
    addVec(1, 'h14,  'hA4,  'h10,  0,   1,  0,  0,     1, 3,  0);
    addVec(0, 0,     0,     'h99,  0,   1,  0,  0,     1, 3,  0);
    addVec(0, 0,     0,     'h99,  0,   1,  0,  0,     1, 2,  0);
    addVec(0, 0,     0,     'h14,  0,   1,  1,  'hA4,  1, 1,  0);
    addVec(0, 0,     0,     'h14,  0,   1,  0,  0,     0, 0,  1);
    // youngest match wins
    addVec(1, 'h5,   'h1,   'h5,   1,   1,  0,  0,     0, 0,  1);
    addVec(1, 'h5,   'h2,   'h5,   1,   1,  1,  'h1,   0, 1,  0);
    addVec(0, 0,     0,     'h5,   1,   1,  1,  'h2,   0, 2,  0);
    addVec(0, 0,     0,     'h6,   1,   1,  0,  0,     0, 2,  0);
    addVec(0, 0,     0,     'h5,   0,   1,  1,  'h2,   1, 2,  0);
    addVec(0, 0,     0,     'h5,   0,   1,  1,  'h2,   1, 1,  0);
    addVec(0, 0,     0,     'h5,   0,   1,  0,  0,     0, 0,  1);
    // same-cycle push not visible until the next cycle
    addVec(1, 'h8,   'h88,  'h8,   1,   1,  0,  0,     0, 0,  1);
    addVec(0, 0,     0,     'h8,   1,   1,  1,  'h88,  0, 1,  0);
    addVec(0, 0,     0,     'h8,   0,   1,  1,  'h88,  1, 1,  0);
    addVec(0, 0,     0,     'h8,   0,   1,  0,  0,     0, 0,  1);

    // reset state
    #2;
    checkOutput("reset_count", 64'(count_o), 0);
    checkOutput("reset_empty", 64'(empty_o), 1);
    checkOutput("reset_ready", 64'(st_ready_o), 1);
    checkOutput("reset_write", 64'(mem_write_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stValid, vecs[i].stAddr, vecs[i].stData,
                    vecs[i].ldAddr, vecs[i].memBusy);
      checkOutput($sformatf("v%0d_ready", i), 64'(st_ready_o), 64'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_hit", i), 64'(ld_hit_o), 64'(vecs[i].expHit));
      checkOutput($sformatf("v%0d_lddata", i), ld_data_o, vecs[i].expLdData);
      checkOutput($sformatf("v%0d_write", i), 64'(mem_write_o), 64'(vecs[i].expWrite));
      checkOutput($sformatf("v%0d_count", i), 64'(count_o), 64'(vecs[i].expCount));
      checkOutput($sformatf("v%0d_empty", i), 64'(empty_o), 64'(vecs[i].expEmpty));
      if (vecs[i].expEmpty) begin
        checkOutput($sformatf("v%0d_memaddr0", i), mem_addr_out_o, 0);
        checkOutput($sformatf("v%0d_wdata0", i), write_data_o, 0);
      end
      @(negedge clk_i);
    end

    // Steady push and pop at occupancy two across several pointer wraps.
    applyStimulus(1, 'h100, 64'($urandom), 'h0, 1);
    @(negedge clk_i);
    applyStimulus(1, 'h101, 64'($urandom), 'h0, 1);
    @(negedge clk_i);
    for (int i = 2; i < 10; i++) begin
      applyStimulus(1, 64'('h100 + i), 64'($urandom), 'h0, 0);
      checkOutput($sformatf("wrap%0d_count", i), 64'(count_o), 2);
      @(negedge clk_i);
    end
    for (int i = 0; i < 10 && !empty_o; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk_i);
    end
    checkOutput("wrap_drained", 64'(empty_o), 1);
    checkOutput("wrap_sb_empty", 64'(sbQ.size()), 0);

    // Asynchronous reset in the middle of a cycle with stores pending.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 64'('h200 + i), 64'('hC0 + i), 'h201, 1);
      @(negedge clk_i);
    end
    applyStimulus(0, 0, 0, 'h201, 1);
    checkOutput("prereset_count", 64'(count_o), 3);
    checkOutput("prereset_hit", 64'(ld_hit_o), 1);
    #1;
    rst_ni     = 1'b0;
    mem_busy_i = 1'b0;
    #1;
    checkOutput("rst_count", 64'(count_o), 0);
    checkOutput("rst_empty", 64'(empty_o), 1);
    checkOutput("rst_ready", 64'(st_ready_o), 1);
    checkOutput("rst_write", 64'(mem_write_o), 0);
    checkOutput("rst_memaddr", mem_addr_out_o, 0);
    checkOutput("rst_wdata", write_data_o, 0);
    checkOutput("rst_hit", 64'(ld_hit_o), 0);
    checkOutput("rst_lddata", ld_data_o, 0);
    sbQ.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 'h201, 0);
      checkOutput($sformatf("postrst%0d_write", i), 64'(mem_write_o), 0);
      checkOutput($sformatf("postrst%0d_count", i), 64'(count_o), 0);
      @(negedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
